mmio_uart_port_responder: RTL and testbench
===========================================

// Module: mmio_uart_port_responder
// PURPOSE
//  Memory-mapped I/O responder on the processor's data-memory bus: the target end of the core's load/store accesses.
//  Decodes a 16-byte window at BASE_ADDR and hosts a PortOut latch, a synchronized PortIn and a UART transmitter
//  fed by a byte FIFO. Reads are combinational so the single-cycle core completes a load in the issuing cycle.
// PARAMETERS
//  BASE_ADDR     32'h1001_0000  base of the 16-byte register window (bits [3:0] must be 0)
//  CLKS_PER_BIT  16             clk cycles per UART bit (>=2)
//  FIFO_DEPTH    4              TX FIFO entries; power of 2, >=2
// PORTS
//  clk        in   1   single clock, rising edge
//  reset      in   1   asynchronous, active-low reset
//  Address    in   32  byte address from ALU result
//  WriteData  in   32  store data (Rt)
//  MemWrite   in   1   store strobe, sampled at clk edge
//  MemRead    in   1   load strobe
//  PortIn     in   8   external asynchronous input pins
//  ReadData   out  32  load data, valid same cycle as MemRead
//  Hit        out  1   Address within window (core muxes ReadData vs RAM)
//  PortOut    out  32  output port latch
//  TxSerial   out  1   UART line, 8N1, idle high
//  TxBusy     out  1   serializer not idle
// BEHAVIOUR
//  Decode: Hit = (Address[31:4] == BASE_ADDR[31:4]); offset = Address[3:2]; Address[1:0] ignored.
//  Map: 0x0 TXDATA (W: push WriteData[7:0]; R: 0) | 0x4 STATUS (R; W of any value clears overflow)
//       0x8 PORTOUT (R/W, 32b) | 0xC PORTIN (R: {24'b0, synced PortIn}; W ignored).
//  STATUS = {count[27:0-extended to bits 31:4]=0 except bits[7:4]=FIFO count, b3 overflow, b2 fifo_empty, b1 fifo_full, b0 TxBusy}.
//  ReadData = MemRead & Hit ? selected register : 32'h0; purely combinational, no read side effects.
//  Writes take effect at the clk edge where MemWrite & Hit; no effect when Hit=0.
//  Push when FIFO full: byte dropped, overflow sets (sticky) same edge; STATUS clear and overflow set same edge -> set wins.
//  PortIn: 2-flop synchronizer, 2-cycle latency, no debounce.
//  Serializer FSM: IDLE -> START -> DATA -> STOP -> IDLE.
//   IDLE: TxSerial=1; if FIFO non-empty, pop head into shift reg this edge, go START.
//   START: TxSerial=0 for CLKS_PER_BIT cycles. DATA: 8 bits LSB first, CLKS_PER_BIT each, 3-bit index.
//   STOP: TxSerial=1 for CLKS_PER_BIT cycles, then IDLE (next byte may pop on the following edge).
//   Frame = 10*CLKS_PER_BIT cycles + 1 IDLE cycle between back-to-back bytes.
//  TxBusy = (state != IDLE). TxSerial registered, glitch-free.
//  Simultaneous push and pop: both occur, count unchanged; push into full FIFO with same-edge pop succeeds.
//  Push into empty FIFO: byte leaves on next IDLE edge (>=1 cycle), never bypasses FIFO.
//  Pointers wrap modulo FIFO_DEPTH; count is log2(FIFO_DEPTH)+1 bits.
//  Reset (asynchronous, any time incl. mid-frame): FSM IDLE, TxSerial=1, TxBusy=0, FIFO empty, count=0,
//   overflow=0, PortOut=0, sync flops=0; ReadData follows combinationally.
// STRUCTURE
//  Shared package/header: register offset constants (TXDATA/STATUS/PORTOUT/PORTIN), STATUS bit indices,
//   serializer state encoding (2-bit localparams).
//  One sub-module: uart_tx_serializer (clk, reset, Start, Data[7:0], TxSerial, Busy), holding FSM, baud counter, bit index.
//  FIFO, decode, PortOut latch and synchronizer stay in this module.
// TESTING
//  1 Reset mid-frame: push 8'hA5, drop reset at cycle 30 -> TxSerial=1, TxBusy=0, STATUS=32'h4 immediately, PortOut=0.
//  2 Single byte, CLKS_PER_BIT=16: store 32'h0000_0055 to 0x0 -> start bit low 16 cycles, bits 1,0,1,0,1,0,1,0, stop high; TxBusy 160 cycles.
//  3 Overflow: 5 stores (0x11..0x15) in consecutive cycles with depth 4, serializer popping 0x11 -> 0x15 accepted? only if pop coincides;
//    check bench scoreboard exactly; then 6th store when full -> STATUS b3=1, byte absent on line; store to 0x4 -> b3=0.
//  4 Simultaneous push/pop: FIFO full, serializer in STOP last cycle, push 0x77 same edge as pop -> count stays 4, no overflow, 0x77 sent last.
//  5 Ports: store 32'hDEAD_BEEF to 0x8 -> PortOut=32'hDEADBEEF next edge, load 0x8 returns it; PortIn=8'h3C -> load 0xC = 32'h3C after 2 cycles.
//  6 Decode: store to BASE_ADDR+0x10 and load from BASE_ADDR-4 -> Hit=0, ReadData=0, no register change.

Source files
------------

// File: rtl/mmio_uart_port_responder_pkg.sv
// -----------------------------------------------------------------------------
// mmio_uart_port_responder_pkg
// Shared definitions for the MMIO UART/port responder:
//   - register word offsets inside the 16-byte window (Address[3:2])
//   - STATUS register bit positions
//   - serializer state encoding (2-bit)
// -----------------------------------------------------------------------------
package mmio_uart_port_responder_pkg;

   // Word offsets (Address[3:2]) of the four registers
   localparam logic [1:0] OFF_TXDATA  = 2'd0;
   localparam logic [1:0] OFF_STATUS  = 2'd1;
   localparam logic [1:0] OFF_PORTOUT = 2'd2;
   localparam logic [1:0] OFF_PORTIN  = 2'd3;

   // STATUS bit positions; the FIFO count occupies bits [7:4]
   localparam int STAT_BUSY    = 0;
   localparam int STAT_FULL    = 1;
   localparam int STAT_EMPTY   = 2;
   localparam int STAT_OVF     = 3;
   localparam int STAT_CNT_LSB = 4;

   // Serializer state encoding
   localparam logic [1:0] SER_IDLE  = 2'd0;
   localparam logic [1:0] SER_START = 2'd1;
   localparam logic [1:0] SER_DATA  = 2'd2;
   localparam logic [1:0] SER_STOP  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = SER_IDLE,
      ST_START = SER_START,
      ST_DATA  = SER_DATA,
      ST_STOP  = SER_STOP
   } ser_state_e;

endpackage

// File: rtl/mmio_uart_port_responder_if.sv
// -----------------------------------------------------------------------------
// mmio_uart_port_responder_if
// Data-memory bus between the core (master) and an MMIO target (slave).
//   Address   : byte address from the ALU
//   WriteData : store data
//   MemWrite  : store strobe, sampled at the clock edge
//   MemRead   : load strobe
//   ReadData  : load data, valid in the same cycle as MemRead
//   Hit       : the target claims the address
// -----------------------------------------------------------------------------
interface mmio_uart_port_responder_if;
   logic [31:0] Address;
   logic [31:0] WriteData;
   logic        MemWrite;
   logic        MemRead;
   logic [31:0] ReadData;
   logic        Hit;

   modport master (
      output Address, WriteData, MemWrite, MemRead,
      input  ReadData, Hit
   );

   modport slave (
      input  Address, WriteData, MemWrite, MemRead,
      output ReadData, Hit
   );
endinterface

// File: rtl/mmio_uart_port_responder_uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
// 8N1 UART transmitter: IDLE -> START -> DATA (8 bits, LSB first) -> STOP.
// Ports:
//   clk      : clock, rising edge
//   reset    : asynchronous active-low reset
//   Start    : byte available; accepted only while IDLE
//   Data     : byte captured on the accepting edge
//   TxSerial : registered line output, idle high
//   Busy     : state is not IDLE
// A frame occupies 10*CLKS_PER_BIT cycles; the one IDLE cycle after STOP
// is where the next byte can be accepted.
// -----------------------------------------------------------------------------
module uart_tx_serializer
   import mmio_uart_port_responder_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       Start,
   input  logic [7:0] Data,
   output logic       TxSerial,
   output logic       Busy
);

   localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   ser_state_e       state_q;
   logic [CNT_W-1:0] baud_q;
   logic [2:0]       bit_idx_q;
   logic [7:0]       shift_q;
   logic             tx_q;
   logic             bit_done_s;

   assign bit_done_s = (baud_q == CNT_LAST);
   assign TxSerial   = tx_q;
   assign Busy       = (state_q != ST_IDLE);

   // Serializer FSM with baud counter, bit index and registered line output
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         baud_q    <= {CNT_W{1'b0}};
         bit_idx_q <= 3'd0;
         shift_q   <= 8'h00;
         tx_q      <= 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               baud_q    <= {CNT_W{1'b0}};
               bit_idx_q <= 3'd0;
               tx_q      <= 1'b1;
               if (Start) begin
                  shift_q <= Data;
                  tx_q    <= 1'b0;          // start bit begins on the accept edge
                  state_q <= ST_START;
               end
            end
            ST_START: begin
               if (bit_done_s) begin
                  baud_q  <= {CNT_W{1'b0}};
                  tx_q    <= shift_q[0];
                  state_q <= ST_DATA;
               end else begin
                  baud_q  <= baud_q + CNT_W'(1);
               end
            end
            ST_DATA: begin
               if (bit_done_s) begin
                  baud_q <= {CNT_W{1'b0}};
                  if (bit_idx_q == 3'd7) begin
                     tx_q    <= 1'b1;
                     state_q <= ST_STOP;
                  end else begin
                     // shift_q[0] is on the line; present the next bit
                     bit_idx_q <= bit_idx_q + 3'd1;
                     shift_q   <= {1'b0, shift_q[7:1]};
                     tx_q      <= shift_q[1];
                  end
               end else begin
                  baud_q <= baud_q + CNT_W'(1);
               end
            end
            ST_STOP: begin
               if (bit_done_s) begin
                  baud_q  <= {CNT_W{1'b0}};
                  tx_q    <= 1'b1;
                  state_q <= ST_IDLE;
               end else begin
                  baud_q  <= baud_q + CNT_W'(1);
               end
            end
            default: begin
               baud_q    <= {CNT_W{1'b0}};
               bit_idx_q <= 3'd0;
               tx_q      <= 1'b1;
               state_q   <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: rtl/mmio_uart_port_responder.sv
// -----------------------------------------------------------------------------
// mmio_uart_port_responder
// MMIO target on the data-memory bus decoding a 16-byte window at BASE_ADDR:
//   0x0 TXDATA  W: push WriteData[7:0] into the TX FIFO; R: 0
//   0x4 STATUS  R: {count[7:4], overflow, empty, full, TxBusy}; W: clear overflow
//   0x8 PORTOUT R/W 32-bit output latch
//   0xC PORTIN  R: {24'b0, synchronized PortIn}
// Ports:
//   clk, reset : clock and asynchronous active-low reset
//   bus        : slave side of the data-memory bus (combinational ReadData/Hit)
//   PortIn     : asynchronous input pins (2-flop synchronized)
//   PortOut    : output port latch
//   TxSerial   : UART line, 8N1, idle high
//   TxBusy     : serializer not idle
// -----------------------------------------------------------------------------
module mmio_uart_port_responder
   import mmio_uart_port_responder_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR    = 32'h1001_0000,
   parameter int          CLKS_PER_BIT = 16,
   parameter int          FIFO_DEPTH   = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   mmio_uart_port_responder_if.slave   bus,
   input  logic [7:0]                  PortIn,
   output logic [31:0]                 PortOut,
   output logic                        TxSerial,
   output logic                        TxBusy
);

   localparam int               PTR_W   = $clog2(FIFO_DEPTH);
   localparam int               CNT_W   = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   logic             hit_s;
   logic [1:0]       offset_s;
   logic             wr_hit_s;
   logic             push_req_s;
   logic             push_ok_s;
   logic             pop_s;
   logic             ovf_set_s;
   logic             ovf_clr_s;
   logic             fifo_full_s;
   logic             fifo_empty_s;
   logic             ser_busy_s;
   logic [1:0]       unused_addr_s;

   logic [7:0]       fifo_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             overflow_q, overflow_d;
   logic [31:0]      portout_q;
   logic [7:0]       sync1_q, sync2_q;
   logic [31:0]      status_s;
   logic [31:0]      rdata_sel_s;

   // Byte lane bits play no part in decode
   assign unused_addr_s = bus.Address[1:0];

   assign hit_s        = (bus.Address[31:4] == BASE_ADDR[31:4]);
   assign offset_s     = bus.Address[3:2];
   assign wr_hit_s     = bus.MemWrite & hit_s;
   assign push_req_s   = wr_hit_s & (offset_s == OFF_TXDATA);
   assign ovf_clr_s    = wr_hit_s & (offset_s == OFF_STATUS);
   assign fifo_full_s  = (count_q == DEPTH_C);
   assign fifo_empty_s = (count_q == {CNT_W{1'b0}});
   assign pop_s        = ~ser_busy_s & ~fifo_empty_s;
   // A push into a full FIFO still lands if the head leaves on the same edge
   assign push_ok_s    = push_req_s & (~fifo_full_s | pop_s);
   assign ovf_set_s    = push_req_s & ~push_ok_s;

   assign PortOut = portout_q;
   assign TxBusy  = ser_busy_s;
   assign bus.Hit = hit_s;

   // FIFO pointer, occupancy and sticky overflow next-state
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (push_ok_s) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_s})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      // set wins over a same-edge clear
      if (ovf_set_s) begin
         overflow_d = 1'b1;
      end else if (ovf_clr_s) begin
         overflow_d = 1'b0;
      end else begin
         overflow_d = overflow_q;
      end
   end

   // FIFO control registers, PortOut latch and PortIn synchronizer
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q   <= {PTR_W{1'b0}};
         rd_ptr_q   <= {PTR_W{1'b0}};
         count_q    <= {CNT_W{1'b0}};
         overflow_q <= 1'b0;
         portout_q  <= 32'h0000_0000;
         sync1_q    <= 8'h00;
         sync2_q    <= 8'h00;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         sync1_q    <= PortIn;
         sync2_q    <= sync1_q;
         if (wr_hit_s && (offset_s == OFF_PORTOUT)) begin
            portout_q <= bus.WriteData;
         end
      end
   end

   // FIFO byte storage
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_q[i] <= 8'h00;
         end
      end else if (push_ok_s) begin
         fifo_q[wr_ptr_q] <= bus.WriteData[7:0];
      end
   end

   // STATUS word assembly
   always_comb begin
      status_s                      = 32'h0000_0000;
      status_s[STAT_CNT_LSB +: 4]   = 4'(count_q);
      status_s[STAT_OVF]            = overflow_q;
      status_s[STAT_EMPTY]          = fifo_empty_s;
      status_s[STAT_FULL]           = fifo_full_s;
      status_s[STAT_BUSY]           = ser_busy_s;
   end

   // Combinational read mux; loads have no side effects
   always_comb begin
      rdata_sel_s = 32'h0000_0000;
      case (offset_s)
         OFF_TXDATA:  rdata_sel_s = 32'h0000_0000;
         OFF_STATUS:  rdata_sel_s = status_s;
         OFF_PORTOUT: rdata_sel_s = portout_q;
         OFF_PORTIN:  rdata_sel_s = {24'h00_0000, sync2_q};
         default:     rdata_sel_s = 32'h0000_0000;
      endcase
      if (bus.MemRead && hit_s) begin
         bus.ReadData = rdata_sel_s;
      end else begin
         bus.ReadData = 32'h0000_0000;
      end
   end

   uart_tx_serializer #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_tx_serializer (
      .clk      (clk),
      .reset    (reset),
      .Start    (pop_s),
      .Data     (fifo_q[rd_ptr_q]),
      .TxSerial (TxSerial),
      .Busy     (ser_busy_s)
   );

endmodule

// File: tb/tb_mmio_uart_port_responder.sv
module tb_mmio_uart_port_responder;

   localparam logic [31:0] BASE = 32'h1001_0000;
   localparam int          CPB  = 16;

   logic        clk   = 1'b0;
   logic        reset = 1'b0;
   logic [7:0]  port_in;
   logic [31:0] port_out;
   logic        tx_serial;
   logic        tx_busy;

   mmio_uart_port_responder_if bus_if ();

   mmio_uart_port_responder #(
      .BASE_ADDR    (BASE),
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (4)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus_if),
      .PortIn   (port_in),
      .PortOut  (port_out),
      .TxSerial (tx_serial),
      .TxBusy   (tx_busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // scoreboard of bytes expected on the UART line, in order
   logic [7:0] exp_q [$];

   typedef struct {
      logic        we;
      logic        re;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic        exp_hit;
      logic [31:0] exp_po;
   } vec_t;

   vec_t vecs [12];

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      bus_if.Address   = a;
      bus_if.WriteData = d;
      bus_if.MemWrite  = 1'b1;
      bus_if.MemRead   = 1'b0;
      @(posedge clk);
      #1;
      bus_if.MemWrite  = 1'b0;
   endtask

   task automatic load_check(input string name, input logic [31:0] a, input logic [31:0] exp);
      bus_if.Address  = a;
      bus_if.MemRead  = 1'b1;
      bus_if.MemWrite = 1'b0;
      #1;
      check32(name, bus_if.ReadData, exp);
      bus_if.MemRead  = 1'b0;
   endtask

   task automatic wait_drain(input string name, input int bound);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || tx_busy) && n < bound) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (exp_q.size() != 0 || tx_busy) begin
         errors++;
         $display("FAIL %s: timeout, %0d bytes still expected, busy=%0b, required 0 and 0", name, exp_q.size(), tx_busy);
      end
      @(posedge clk);
      #1;
   endtask

   // UART line monitor: samples mid-bit on negedges, compares against scoreboard
   int         mon_n;
   logic       mon_active = 1'b0;
   logic       mon_frame_ok;
   logic [7:0] mon_byte;
   logic [7:0] mon_exp;
   always @(negedge clk) begin
      if (!reset) begin
         mon_active <= 1'b0;
      end else if (!mon_active) begin
         if (tx_serial === 1'b0) begin
            mon_active   <= 1'b1;
            mon_n        <= 1;
            mon_frame_ok <= 1'b1;
         end
      end else begin
         mon_n <= mon_n + 1;
         if (mon_n == CPB/2 && tx_serial !== 1'b0) mon_frame_ok <= 1'b0;
         if (mon_n > CPB/2 && mon_n < CPB/2 + 9*CPB && ((mon_n - CPB/2) % CPB) == 0)
            mon_byte[(mon_n - CPB/2)/CPB - 1] <= tx_serial;
         if (mon_n == CPB/2 + 9*CPB) begin
            mon_active <= 1'b0;
            checks++;
            if (!mon_frame_ok || tx_serial !== 1'b1) begin
               errors++;
               $display("FAIL uart_framing: byte 0x%02h start_ok=%0b stop=%0b, required 1 and 1", mon_byte, mon_frame_ok, tx_serial);
            end else if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL uart_byte: got unexpected 0x%02h, required no byte", mon_byte);
            end else begin
               mon_exp = exp_q.pop_front();
               if (mon_byte !== mon_exp) begin
                  errors++;
                  $display("FAIL uart_byte: got 0x%02h expected 0x%02h", mon_byte, mon_exp);
               end
            end
         end
      end
   end

   // global watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1, "timeout");
   end

   initial begin
      int busy_cnt, low_cnt;
      logic seen_low, seen_high, done;

      bus_if.Address   = 32'h0;
      bus_if.WriteData = 32'h0;
      bus_if.MemWrite  = 1'b0;
      bus_if.MemRead   = 1'b0;
      port_in          = 8'h00;

      vecs[0]  = '{1'b1, 1'b0, BASE + 32'h8,  32'hDEAD_BEEF, 32'h0000_0000, 1'b1, 32'hDEAD_BEEF};
      vecs[1]  = '{1'b0, 1'b1, BASE + 32'h8,  32'h0,         32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF};
      vecs[2]  = '{1'b0, 1'b1, BASE + 32'hC,  32'h0,         32'h0000_003C, 1'b1, 32'hDEAD_BEEF};
      vecs[3]  = '{1'b1, 1'b1, BASE + 32'h10, 32'h1234_5678, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
      vecs[4]  = '{1'b0, 1'b1, BASE - 32'h4,  32'h0,         32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
      vecs[5]  = '{1'b1, 1'b1, BASE + 32'hC,  32'hFFFF_FFFF, 32'h0000_003C, 1'b1, 32'hDEAD_BEEF};
      vecs[6]  = '{1'b0, 1'b1, BASE + 32'hC,  32'h0,         32'h0000_003C, 1'b1, 32'hDEAD_BEEF};
      vecs[7]  = '{1'b0, 1'b1, BASE + 32'h0,  32'h0,         32'h0000_0000, 1'b1, 32'hDEAD_BEEF};
      vecs[8]  = '{1'b0, 1'b0, BASE + 32'h8,  32'h0,         32'h0000_0000, 1'b1, 32'hDEAD_BEEF};
      vecs[9]  = '{1'b1, 1'b0, BASE + 32'h9,  32'h0000_00A0, 32'h0000_0000, 1'b1, 32'h0000_00A0};
      vecs[10] = '{1'b0, 1'b1, BASE + 32'hB,  32'h0,         32'h0000_00A0, 1'b1, 32'h0000_00A0};
      vecs[11] = '{1'b0, 1'b1, BASE + 32'h4,  32'h0,         32'h0000_0004, 1'b1, 32'h0000_00A0};

      // reset state
      #12;
      check32("rst_txserial", {31'h0, tx_serial}, 32'h1);
      check32("rst_txbusy",   {31'h0, tx_busy},   32'h0);
      check32("rst_portout",  port_out,           32'h0);
      load_check("rst_status", BASE + 32'h4, 32'h0000_0004);
      load_check("rst_portin", BASE + 32'hC, 32'h0000_0000);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;

      // reset in the middle of a frame
      store(BASE + 32'h8, 32'h1234_5678);
      store(BASE + 32'h0, 32'h0000_00A5);
      exp_q.push_back(8'hA5);
      repeat (39) @(posedge clk);
      #2;
      check32("pre_rst_line_low", {31'h0, tx_serial}, 32'h0);
      check32("pre_rst_busy",     {31'h0, tx_busy},   32'h1);
      reset = 1'b0;
      #1;
      check32("midrst_txserial", {31'h0, tx_serial}, 32'h1);
      check32("midrst_txbusy",   {31'h0, tx_busy},   32'h0);
      check32("midrst_portout",  port_out,           32'h0);
      load_check("midrst_status", BASE + 32'h4, 32'h0000_0004);
      exp_q.delete();
      @(posedge clk);
      @(negedge clk);
      reset   = 1'b1;
      port_in = 8'h3C;
      repeat (3) @(posedge clk);
      #1;

      // register/decode vector table
      for (int i = 0; i < 12; i++) begin
         bus_if.MemWrite  = vecs[i].we;
         bus_if.MemRead   = vecs[i].re;
         bus_if.Address   = vecs[i].addr;
         bus_if.WriteData = vecs[i].wdata;
         #1;
         check32($sformatf("vec%0d_rdata", i), bus_if.ReadData, vecs[i].exp_rd);
         check32($sformatf("vec%0d_hit", i), {31'h0, bus_if.Hit}, {31'h0, vecs[i].exp_hit});
         @(posedge clk);
         #1;
         bus_if.MemWrite = 1'b0;
         bus_if.MemRead  = 1'b0;
         check32($sformatf("vec%0d_portout", i), port_out, vecs[i].exp_po);
      end

      // PortIn synchronizer latency: two edges
      port_in = 8'h5A;
      load_check("portin_0edge", BASE + 32'hC, 32'h0000_003C);
      @(posedge clk);
      #1;
      load_check("portin_1edge", BASE + 32'hC, 32'h0000_003C);
      @(posedge clk);
      #1;
      load_check("portin_2edge", BASE + 32'hC, 32'h0000_005A);

      // single byte: start bit length and busy duration
      store(BASE + 32'h0, 32'h0000_0055);
      exp_q.push_back(8'h55);
      busy_cnt  = 0;
      low_cnt   = 0;
      seen_low  = 1'b0;
      seen_high = 1'b0;
      done      = 1'b0;
      for (int i = 0; i < 400 && !done; i++) begin
         @(negedge clk);
         if (tx_busy) busy_cnt++;
         if (tx_serial == 1'b0 && !seen_high) begin
            seen_low = 1'b1;
            low_cnt++;
         end else if (seen_low) begin
            seen_high = 1'b1;
         end
         if (busy_cnt > 0 && !tx_busy) done = 1'b1;
      end
      check32("busy_cycles",      busy_cnt, 32'd160);
      check32("start_bit_cycles", low_cnt,  32'd16);
      wait_drain("drain_single", 300);

      // overflow: 0x11 pops on the second edge, 0x12..0x15 fill, 0x16 dropped
      for (int b = 8'h11; b <= 8'h15; b++) begin
         store(BASE + 32'h0, 32'(b));
         exp_q.push_back(8'(b));
      end
      store(BASE + 32'h0, 32'h0000_0016);
      load_check("status_overflow", BASE + 32'h4, 32'h0000_004B);
      store(BASE + 32'h4, 32'h0000_0000);
      load_check("status_ovf_clear", BASE + 32'h4, 32'h0000_0043);
      wait_drain("drain_overflow", 1200);

      // push into full FIFO on the edge the head pops (161 cycles after first pop)
      for (int b = 8'h21; b <= 8'h25; b++) begin
         store(BASE + 32'h0, 32'(b));
         exp_q.push_back(8'(b));
      end
      load_check("status_full", BASE + 32'h4, 32'h0000_0043);
      repeat (157) @(posedge clk);
      #1;
      store(BASE + 32'h0, 32'h0000_0077);
      exp_q.push_back(8'h77);
      load_check("status_push_pop", BASE + 32'h4, 32'h0000_0043);
      wait_drain("drain_push_pop", 1500);
      load_check("status_final", BASE + 32'h4, 32'h0000_0004);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
